ofm_packer: RTL and testbench
=============================

OFM_PACKER -- requirements
Module: ofm_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of the signed accumulator result arriving from the fully-connected stage.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 8, meaning the width of one quantized output lane.
REQ-003 The block SHALL have parameter LANES, default 8, meaning the number of lanes packed per output word.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of packed words the output FIFO holds (power of two).
REQ-005 The block SHALL have port clk1, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port ofm, input, DATA_WIDTH bits, the signed result from the upstream fully-connected stage.
REQ-008 The block SHALL have port valid_data, input, 1 bit; ofm is accepted on every edge where it is high, with no backpressure.
REQ-009 The block SHALL have port flush, input, 1 bit, a pulse that closes a partial word.
REQ-010 The block SHALL have port shift, input, 4 bits, the arithmetic right-shift amount, static while valid_data is active.
REQ-011 The block SHALL have port out_data, output, LANES*OUT_WIDTH bits, the packed word; lane 0 occupies the LSBs.
REQ-012 The block SHALL have port out_valid, output, 1 bit, high when the FIFO is not empty.
REQ-013 The block SHALL have port out_ready, input, 1 bit, consumer handshake.
REQ-014 The block SHALL have port overflow, output, 1 bit, sticky flag set when a word is dropped.
REQ-015 The block SHALL have port word_cnt, output, 16 bits, the count of words pushed into the FIFO; it wraps modulo 2^16.

Function
REQ-016 The stage-1 register SHALL capture q = sat(round(ofm >>> shift)) and a qualifier on each valid_data edge; rounding SHALL be half-up by adding 1<<(shift-1) before the shift when shift>0.
REQ-017 Saturation SHALL clamp to the signed OUT_WIDTH range [-128, 127] at default parameters.
REQ-018 On the edge after stage-1 holds a qualified sample, that sample SHALL be written to lane lane_idx, and lane_idx SHALL increment by one.
REQ-019 When the written lane is LANES-1, the complete word (7 held lanes plus the current q) SHALL be pushed into the FIFO on that same edge, lane_idx SHALL return to 0, and the lane registers SHALL clear to 0.
REQ-020 Latency SHALL be as follows: when the 8th sample is sampled at edge E and the FIFO is empty, out_valid SHALL be high after edge E+1.
REQ-021 A flush is registered alongside stage 1. If lane_idx is greater than 0 after any sample on the same cycle is written, the partial word SHALL be pushed with the unused lanes set to 0. A flush with lane_idx equal to 0 SHALL have no effect.
REQ-022 When a flush and the 8th sample arrive together, exactly one word SHALL be pushed.
REQ-023 The FIFO SHALL pop on every edge where out_valid and out_ready are both high; out_data SHALL show the head word and hold stable while out_valid is high and out_ready is low.
REQ-024 When a push finds the FIFO full and no pop occurs on the same edge, the word SHALL be dropped, overflow SHALL be set, and word_cnt SHALL not increment.
REQ-025 When a push and a pop coincide on a full FIFO, both SHALL succeed and no drop SHALL occur.
REQ-026 When a push and a pop coincide on an empty FIFO, the push SHALL complete; out_valid SHALL rise on the next cycle and no pop SHALL occur.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-028 While rst is high, asynchronously: out_valid=0, out_data=0, overflow=0, word_cnt=0, lane_idx=0, all lane registers 0, stage-1 qualifier 0, FIFO pointers 0.
REQ-029 Reset asserted mid-word or mid-FIFO SHALL discard all held data; the first sample after release SHALL land in lane 0.

Configuration
REQ-030 When OFM_PACKER_RELU_EN is defined, a ReLU SHALL be applied after saturation, so negative q becomes 0 and the lane range is [0, 127].
REQ-031 When OFM_PACKER_RELU_EN is not defined, lanes SHALL carry signed two's-complement saturated values with no ReLU.

Verification
REQ-032 Scenario: shift=2, ofm 262, then 7 samples of 0 -> lane 0 = 66 (rounded), lanes 1-7 = 0, out_valid high after edge E+1.
REQ-033 Scenario: shift=0, ofm 0x7FFF and 0x8000 -> 127; and -128, or 0 with RELU_EN.
REQ-034 Scenario: 3 samples of 5 then flush -> single word 0x0000000000050505; word_cnt=1.
REQ-035 Scenario: out_ready=0, 40 continuous valid samples -> 4 words stored, 5th dropped, overflow=1, word_cnt=4; head word unchanged.
REQ-036 Scenario: FIFO full, 8th sample completes with out_ready=1 on the same edge -> no drop, overflow stays 0, occupancy stays 4.
REQ-037 Scenario: rst pulsed after 5 samples -> all outputs 0; next 8 samples form one word with the first sample in lane 0.

Source files
------------

// File: rtl/ofm_packer.sv
`default_nettype none
// ============================================================================
// Module   : ofm_packer
// Brief    : Quantizes fully-connected results and packs LANES lanes per word into an output FIFO.
//            Define OFM_PACKER_RELU_EN to clamp negative lanes to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ofm_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int LANES      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk1,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        ofm,
  input  logic                         valid_data,
  input  logic                         flush,
  input  logic [3:0]                   shift,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [15:0]                  word_cnt
);

  localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_EXT_W  = DATA_WIDTH + 1;
  localparam int c_WORD_W = LANES * OUT_WIDTH;
  localparam logic [c_IDX_W-1:0]        c_LAST = c_IDX_W'(LANES - 1);
  localparam logic signed [c_EXT_W-1:0] c_QMAX = c_EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [c_EXT_W-1:0] c_QMIN = ~c_QMAX;

  // One extra bit keeps the rounding bias from overflowing the input range
  logic signed [c_EXT_W-1:0] w_ext;
  logic signed [c_EXT_W-1:0] w_bias;
  logic signed [c_EXT_W-1:0] w_rnd;
  logic signed [c_EXT_W-1:0] w_shr;
  logic [OUT_WIDTH-1:0]      w_sat;
  logic [OUT_WIDTH-1:0]      w_q;

  assign w_ext  = {ofm[DATA_WIDTH-1], ofm};
  assign w_bias = (shift == 4'd0) ? '0 : (c_EXT_W'(1) << (shift - 4'd1));
  assign w_rnd  = w_ext + w_bias;
  assign w_shr  = w_rnd >>> shift;

  always_comb begin
    w_sat = w_shr[OUT_WIDTH-1:0];
    if (w_shr > c_QMAX) begin
      w_sat = c_QMAX[OUT_WIDTH-1:0];
    end else if (w_shr < c_QMIN) begin
      w_sat = c_QMIN[OUT_WIDTH-1:0];
    end
  end

`ifdef OFM_PACKER_RELU_EN
  assign w_q = w_sat[OUT_WIDTH-1] ? '0 : w_sat;
`else
  assign w_q = w_sat;
`endif

  logic [OUT_WIDTH-1:0] r_s1_q;
  logic                 r_s1_vld;
  logic                 r_s1_flush;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_s1_q     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_flush <= 1'b0;
    end else begin
      r_s1_q     <= w_q;
      r_s1_vld   <= valid_data;
      r_s1_flush <= flush;
    end
  end

  logic [OUT_WIDTH-1:0] r_lane [LANES];
  logic [c_IDX_W-1:0]   r_lane_idx;
  logic [c_WORD_W-1:0]  w_word;
  logic                 w_last;
  logic                 w_push_req;

  // The outgoing word already includes the sample being written this edge
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_word[i*OUT_WIDTH +: OUT_WIDTH] =
      (r_s1_vld && (r_lane_idx == c_IDX_W'(i))) ? r_s1_q : r_lane[i];
  end

  assign w_last     = r_s1_vld && (r_lane_idx == c_LAST);
  assign w_push_req = w_last || (r_s1_flush && (r_s1_vld || (r_lane_idx != '0)));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_lane_idx <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else if (w_push_req) begin
      r_lane_idx <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else if (r_s1_vld) begin
      r_lane[r_lane_idx] <= r_s1_q;
      r_lane_idx         <= r_lane_idx + 1'b1;
    end
  end

  logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W:0]    r_wr_ptr;
  logic [c_PTR_W:0]    r_rd_ptr;
  logic                r_overflow;
  logic [15:0]         r_word_cnt;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_drop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_pop     = !w_empty && out_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign w_push_ok = w_push_req && (!w_full || w_pop);
  assign w_drop    = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk1) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];
  assign overflow  = r_overflow;
  assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ofm_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_packer
// Brief    : Self-checking bench for ofm_packer against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_packer;

  localparam int DW = 16;
  localparam int OW = 8;
  localparam int LN = 8;
  localparam int FD = 4;
  localparam int WW = LN * OW;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ofm = '0;
  logic          valid_data = 1'b0;
  logic          flush = 1'b0;
  logic [3:0]    shift = 4'd0;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          overflow;
  logic [15:0]   word_cnt;

  always #5 clk1 = ~clk1;

  ofm_packer #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .LANES     (LN),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .ofm       (ofm),
    .valid_data(valid_data),
    .flush     (flush),
    .shift     (shift),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .word_cnt  (word_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] quant(input logic [15:0] x, input logic [3:0] s);
    int v;
    v = int'($signed(x));
    if (s != 4'd0) v = (v + (1 << (int'(s) - 1))) >>> s;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
`ifdef OFM_PACKER_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[7:0];
  endfunction

  // Reference model: pending lanes and FIFO contents as queues
  logic [7:0]    m_lanes[$];
  logic [WW-1:0] m_fifo[$];
  logic [7:0]    m_s1_q;
  bit            m_s1_vld, m_s1_flush, m_ovf, m_pop, m_push, m_full;
  logic [15:0]   m_cnt;
  logic [WW-1:0] m_w;

  always @(posedge clk1 or posedge rst) begin
    if (rst) begin
      m_lanes.delete();
      m_fifo.delete();
      m_s1_q = '0; m_s1_vld = 0; m_s1_flush = 0; m_ovf = 0; m_cnt = '0;
    end else begin
      m_pop = (m_fifo.size() > 0) && out_ready;
      m_full = (m_fifo.size() == FD);
      if (m_s1_vld) m_lanes.push_back(m_s1_q);
      m_push = (m_lanes.size() == LN) || (m_s1_flush && m_lanes.size() > 0);
      m_w = '0;
      if (m_push) begin
        foreach (m_lanes[i]) m_w[i*OW +: OW] = m_lanes[i];
        m_lanes.delete();
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_push) begin
        if (!m_full || m_pop) begin
          m_fifo.push_back(m_w);
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      m_s1_vld = valid_data;
      m_s1_flush = flush;
      m_s1_q = quant(ofm, shift);
    end
  end

  always @(negedge clk1) begin
    if (rst) begin
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_cnt", 64'(word_cnt), 64'd0);
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_fifo.size() > 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
      if (m_fifo.size() > 0) chk("out_data", out_data, m_fifo[0]);
    end
  end

  task automatic put(input bit v, input logic [15:0] d, input bit f);
    valid_data = v; ofm = d; flush = f;
    @(negedge clk1);
  endtask

  task automatic idle(input int n);
    repeat (n) put(0, 16'd0, 0);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    put(0, 16'd0, 0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1; valid_data = 1'b0; flush = 1'b0;
    @(negedge clk1);
    chk("lit_rst_valid", 64'(out_valid), 64'd0);
    chk("lit_rst_cnt", 64'(word_cnt), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk1);
  endtask

  logic [15:0] cnt0;
  int          k;
  int          pr;

  initial begin
    repeat (3) @(negedge clk1);
    chk("lit_reset_valid", 64'(out_valid), 64'd0);
    chk("lit_reset_data", out_data, 64'd0);
    chk("lit_reset_ovf", 64'(overflow), 64'd0);
    chk("lit_reset_cnt", 64'(word_cnt), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk1);

    // Rounding and latency: 262 >> 2 rounds to 66
    shift = 4'd2;
    put(1, 16'd262, 0);
    repeat (7) put(1, 16'd0, 0);
    chk("lat_edge_e", 64'(out_valid), 64'd0);
    put(0, 16'd0, 0);
    chk("lat_edge_e1", 64'(out_valid), 64'd1);
    chk("round_word", out_data, 64'h42);
    pop_one();

    // Saturation at both rails
    shift = 4'd0;
    put(1, 16'h7FFF, 0);
    put(1, 16'h8000, 1);
    put(0, 16'd0, 0);
`ifdef OFM_PACKER_RELU_EN
    chk("sat_word", out_data, 64'h007F);
`else
    chk("sat_word", out_data, 64'h807F);
`endif
    pop_one();

    // Partial word via flush
    cnt0 = word_cnt;
    put(1, 16'd5, 0); put(1, 16'd5, 0); put(1, 16'd5, 1);
    put(0, 16'd0, 0);
    chk("flush_word", out_data, 64'h0000000000050505);
    idle(3);
    chk("flush_cnt", 64'(word_cnt - cnt0), 64'd1);
    pop_one();

    // Flush with nothing held does nothing
    cnt0 = word_cnt;
    put(0, 16'd0, 1);
    idle(3);
    chk("empty_flush_valid", 64'(out_valid), 64'd0);
    chk("empty_flush_cnt", 64'(word_cnt - cnt0), 64'd0);

    // Flush coinciding with the 8th sample pushes exactly one word
    cnt0 = word_cnt;
    repeat (7) put(1, 16'd1, 0);
    put(1, 16'd1, 1);
    idle(3);
    chk("flush8_cnt", 64'(word_cnt - cnt0), 64'd1);
    pop_one();

    // Overflow: 40 samples with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) put(1, 16'(i + 1), 0);
    idle(3);
    chk("ovf_cnt", 64'(word_cnt), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", out_data, 64'h0807060504030201);

    // Full FIFO, push coincides with pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) put(1, 16'(i), 0);
    idle(2);
    for (int i = 0; i < 7; i++) put(1, 16'(i), 0);
    put(1, 16'd9, 0);
    out_ready = 1'b1;
    put(0, 16'd0, 0);
    out_ready = 1'b0;
    chk("fullpp_ovf", 64'(overflow), 64'd0);
    chk("fullpp_cnt", 64'(word_cnt), 64'd5);
    k = 0;
    out_ready = 1'b1;
    repeat (12) begin
      if (out_valid) k++;
      put(0, 16'd0, 0);
    end
    out_ready = 1'b0;
    chk("fullpp_occupancy", 64'(k), 64'd4);

    // Reset mid-word discards held lanes
    for (int i = 0; i < 5; i++) put(1, 16'(100 + i), 0);
    do_reset();
    for (int i = 0; i < 8; i++) put(1, 16'(i + 1), 0);
    idle(2);
    chk("post_rst_word", out_data, 64'h0807060504030201);
    chk("post_rst_cnt", 64'(word_cnt), 64'd1);
    pop_one();

    // Randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      shift = 4'($urandom_range(0, 15));
      pr = $urandom_range(0, 3);
      repeat (300) begin
        out_ready = ($urandom_range(0, 3) >= pr);
        put($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0);
      end
      if (blk == 5) do_reset();
    end
    out_ready = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
